// File: rtl/sparse_win_loader_if.sv
// rtl/sparse_win_loader_if.sv - element stream in / assembled window out handshake bundle
//
// Ports (signals carried by the bundle):
//   in_data   [DATA_W]          streamed activation element (unsigned)
//   in_valid                    in_data valid this cycle
//   in_last                     beat closes the window early
//   in_ready                    loader can accept a beat
//   win_data  [WIN-1:0][DATA_W] assembled window, lane i = i-th accepted beat
//   win_cnt   [$clog2(WIN)+1]   real elements in win_data
//   win_valid                   win_data/win_cnt hold a complete window
//   win_ready                   downstream consumes the window this cycle
// Modports: slave = loader side, master = producer/consumer side.
interface sparse_win_loader_if #(
  parameter int DATA_W = 8,
  parameter int WIN    = 8
);
  localparam int CNT_W = $clog2(WIN) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;

  logic [DATA_W-1:0] win_data [WIN-1:0];
  logic [CNT_W-1:0]  win_cnt;
  logic              win_valid;
  logic              win_ready;

  modport slave (
    input  in_data, in_valid, in_last, win_ready,
    output in_ready, win_data, win_cnt, win_valid
  );

  modport master (
    output in_data, in_valid, in_last, win_ready,
    input  in_ready, win_data, win_cnt, win_valid
  );
endinterface

// File: rtl/sparse_win_loader.sv
// rtl/sparse_win_loader.sv - ping-pong window assembler feeding a WIN-lane max tree
//
// Ports:
//   clk    input  single clock, all state on rising edge
//   reset  input  synchronous active-low reset
//   bus    slave  sparse_win_loader_if (in_* element stream, win_* window output)
// Two banks alternate: one fills from the stream while the other is presented
// downstream, so windows flow at one element per cycle with no boundary bubble.
module sparse_win_loader #(
  parameter int DATA_W = 8,
  parameter int WIN    = 8
) (
  input  logic               clk,
  input  logic               reset,
  sparse_win_loader_if.slave bus
);
  localparam int PTR_W = $clog2(WIN);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] bank_data [2][WIN];
  logic [CNT_W-1:0]  bank_cnt  [2];
  logic [1:0]        bank_full;
  logic              wr_sel;
  logic              rd_sel;
  logic [PTR_W-1:0]  wr_ptr;

  logic in_xfer;
  logic out_xfer;
  logic close_win;

  // in_ready depends only on registered state, never on in_valid.
  assign bus.in_ready  = !bank_full[wr_sel];
  assign in_xfer       = bus.in_valid && !bank_full[wr_sel];
  assign out_xfer      = bank_full[rd_sel] && bus.win_ready;
  // A last-lane beat with in_last set still closes just one window.
  assign close_win     = in_xfer && ((wr_ptr == PTR_W'(WIN - 1)) || bus.in_last);

  assign bus.win_valid = bank_full[rd_sel];
  assign bus.win_cnt   = bank_cnt[rd_sel];

  for (genvar g = 0; g < WIN; g++) begin : g_lane
    assign bus.win_data[g] = bank_data[rd_sel][g];
  end

  // Closing and draining in the same cycle always touch different banks: the
  // write bank is empty (it accepted a beat) and the read bank is full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bank_full <= '0;
      wr_ptr    <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_cnt[b] <= '0;
        for (int i = 0; i < WIN; i++) begin
          bank_data[b][i] <= '0;
        end
      end
    end else begin
      if (in_xfer) begin
        for (int i = 0; i < WIN; i++) begin
          if (PTR_W'(i) == wr_ptr) begin
            bank_data[wr_sel][i] <= bus.in_data;
          end else if (close_win && (PTR_W'(i) > wr_ptr)) begin
            // Clear lanes left over from an older, longer window in this bank.
            bank_data[wr_sel][i] <= '0;
          end
        end
        if (close_win) begin
          bank_full[wr_sel] <= 1'b1;
          bank_cnt[wr_sel]  <= CNT_W'(wr_ptr) + CNT_W'(1);
          wr_ptr            <= '0;
          wr_sel            <= ~wr_sel;
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      if (out_xfer) begin
        bank_full[rd_sel] <= 1'b0;
        rd_sel            <= ~rd_sel;
      end
    end
  end
endmodule

// File: tb/tb_sparse_win_loader.sv
// tb/tb_sparse_win_loader.sv - self-checking bench for sparse_win_loader
module tb_sparse_win_loader;
  localparam int DW = 8;
  localparam int W  = 8;
  localparam int VW = DW * W;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sparse_win_loader_if #(.DATA_W(DW), .WIN(W)) bus ();

  sparse_win_loader #(.DATA_W(DW), .WIN(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  // Reference model: beats of the window being built, and closed windows
  // awaiting delivery (lane i at bits [i*DW +: DW], unused lanes zero).
  logic [DW-1:0] cur[$];
  logic [VW-1:0] exp_win[$];
  int            exp_cnt[$];

  logic          s_in_ready;
  logic          s_win_valid;
  logic [3:0]    s_win_cnt;
  logic [VW-1:0] s_vec;
  logic          s_acc;
  logic          s_out;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at the falling edge, update model, then pass the rising edge.
  task automatic step();
    logic [VW-1:0] v;
    @(negedge clk);
    s_in_ready  = bus.in_ready;
    s_win_valid = bus.win_valid;
    s_win_cnt   = bus.win_cnt;
    for (int i = 0; i < W; i++) s_vec[i*DW +: DW] = bus.win_data[i];
    s_acc = reset && bus.in_valid && s_in_ready;
    s_out = reset && s_win_valid && bus.win_ready;
    if (!reset) begin
      cur.delete();
      exp_win.delete();
      exp_cnt.delete();
    end else begin
      chk("in_ready_vs_occupancy", VW'(s_in_ready), VW'(exp_cnt.size() < 2));
      chk("win_valid_vs_occupancy", VW'(s_win_valid), VW'(exp_cnt.size() > 0));
      if (s_out && exp_cnt.size() > 0) begin
        n_out++;
        chk("win_cnt", VW'(s_win_cnt), VW'(exp_cnt.pop_front()));
        chk("win_data", s_vec, exp_win.pop_front());
      end
      if (s_acc) begin
        cur.push_back(bus.in_data);
        if (cur.size() == W || bus.in_last) begin
          v = '0;
          foreach (cur[i]) v[i*DW +: DW] = cur[i];
          exp_win.push_back(v);
          exp_cnt.push_back(cur.size());
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!s_acc && n < 100);
    if (!s_acc) chk("send_timeout", VW'(s_acc), VW'(1));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.win_ready = 1'b1;
    while (exp_cnt.size() > 0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk("drain_empty", VW'(exp_cnt.size()), VW'(0));
  endtask

  logic [DW-1:0] beats31 [8];
  int k;
  int n;
  int base;
  int drops;

  initial begin
    beats31 = '{8'h05, 8'h40, 8'h12, 8'h3F, 8'h00, 8'h22, 8'h07, 8'h31};
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.win_ready = 1'b0;

    // Reset state
    reset = 1'b0;
    step();
    step();
    chk("reset_in_ready", VW'(s_in_ready), VW'(1));
    chk("reset_win_valid", VW'(s_win_valid), VW'(0));
    chk("reset_win_cnt", VW'(s_win_cnt), VW'(0));
    chk("reset_win_data", s_vec, VW'(0));
    reset = 1'b1;

    // Full window, visible one cycle after the 8th beat, gone the next
    bus.win_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(beats31[i], 1'b0);
    step();
    chk("full_valid", VW'(s_win_valid), VW'(1));
    chk("full_cnt", VW'(s_win_cnt), VW'(8));
    chk("full_data", s_vec, 64'h3107_2200_3F12_4005);
    step();
    chk("full_cleared", VW'(s_win_valid), VW'(0));

    // Partial window closed by in_last
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    step();
    chk("part_cnt", VW'(s_win_cnt), VW'(3));
    chk("part_data", s_vec, 64'h0000_0000_0033_2211);

    // in_last on the last lane closes a single window
    for (int i = 1; i <= 8; i++) send(DW'(i), i == 8);
    step();
    chk("last_lane_cnt", VW'(s_win_cnt), VW'(8));
    step();
    chk("last_lane_no_empty", VW'(s_win_valid), VW'(0));

    // in_last without in_valid is ignored
    bus.in_last = 1'b1;
    repeat (3) step();
    bus.in_last = 1'b0;
    chk("idle_last_no_window", VW'(s_win_valid), VW'(0));
    send(8'h5A, 1'b1);
    step();
    chk("single_cnt", VW'(s_win_cnt), VW'(1));
    chk("single_data", s_vec, 64'h0000_0000_0000_005A);
    step();

    // Backpressure: both banks fill, first window held, then drain in order
    base = n_out;
    bus.win_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b0;
    k = 0;
    n = 0;
    while (k < 16 && n < 200) begin
      bus.in_data = DW'(8'h80 + k);
      step();
      if (s_acc) k++;
      n++;
    end
    chk("bp_accept16", VW'(k), VW'(16));
    bus.in_data = 8'h90;
    repeat (3) begin
      step();
      chk("bp_in_ready_low", VW'(s_in_ready), VW'(0));
      chk("bp_hold_data", s_vec, 64'h8786_8584_8382_8180);
    end
    bus.win_ready = 1'b1;
    step();
    chk("bp_drain_ready_low", VW'(s_in_ready), VW'(0));
    step();
    chk("bp_ready_rise", VW'(s_in_ready), VW'(1));
    if (s_acc) k++;
    n = 0;
    while (k < 20 && n < 200) begin
      bus.in_data = DW'(8'h80 + k);
      bus.in_last = (k == 19);
      step();
      if (s_acc) k++;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    drain();
    chk("bp_windows", VW'(n_out - base), VW'(3));

    // Streaming: one element per cycle, no bubbles
    base  = n_out;
    drops = 0;
    k = 0;
    n = 0;
    bus.win_ready = 1'b1;
    bus.in_valid  = 1'b1;
    while (k < 64 && n < 200) begin
      bus.in_data = DW'(k);
      step();
      if (!s_in_ready) drops++;
      if (s_acc) k++;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("stream_no_drop", VW'(drops), VW'(0));
    chk("stream_cycles", VW'(n), VW'(64));
    drain();
    chk("stream_windows", VW'(n_out - base), VW'(8));

    // Reset in the middle of a window
    for (int i = 0; i < 5; i++) send(DW'(8'h60 + i), 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("mid_reset_win_valid", VW'(s_win_valid), VW'(0));
    chk("mid_reset_in_ready", VW'(s_in_ready), VW'(1));
    for (int i = 0; i < 8; i++) send(DW'(8'hA0 + i), 1'b0);
    step();
    chk("post_reset_cnt", VW'(s_win_cnt), VW'(8));
    chk("post_reset_data", s_vec, 64'hA7A6_A5A4_A3A2_A1A0);
    step();

    // Random valid/ready/last against the model
    k = 0;
    n = 0;
    while (k < 1000 && n < 20000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_data   = DW'($urandom);
      bus.in_last   = (k == 999) || ($urandom_range(0, 5) == 0);
      bus.win_ready = ($urandom_range(0, 9) < 6);
      step();
      if (s_acc) k++;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("rand_accept", VW'(k), VW'(1000));
    drain();
    chk("rand_no_partial", VW'(cur.size()), VW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
